hs32_fetch: RTL

//  Instruction fetch stage: producer side of the fetch->decode handshake (instd/ackd/reqd).

---
 rtl/hs32_fetch_pkg.sv | 22 ++
 rtl/hs32_fetch_fifo.sv | 72 +++++++
 rtl/hs32_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hs32_fetch_pkg.sv
// Shared types and constants for the hs32 instruction fetch stage.
package hs32_fetch_pkg;

    localparam int          HS32_WORD      = 32;
    localparam logic [31:0] HS32_RESET_VEC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [HS32_WORD-1:0] pc;
        logic [HS32_WORD-1:0] word;
    } fetch_entry_t;

    function automatic logic [HS32_WORD-1:0] word_align(input logic [HS32_WORD-1:0] addr);
        return {addr[HS32_WORD-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/hs32_fetch_fifo.sv
// Synchronous prefetch FIFO with a registered head word; clear overrides push/pop.
module hs32_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [W-1:0]  head_reg;
    logic          do_push;
    logic          do_pop;

    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign count       = count_reg;
    assign head        = head_reg;
    assign rd_ptr_next = rd_ptr_reg + AW'(1);
    assign do_pop      = pop && !empty;
    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_push     = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
            // Head register mirrors mem_reg[rd_ptr]; refill it from the next entry or bypass din.
            if (do_pop) begin
                if (count_reg > CW'(1)) begin
                    head_reg <= mem_reg[rd_ptr_next];
                end else if (do_push) begin
                    head_reg <= din;
                end
            end else if (do_push && empty) begin
                head_reg <= din;
            end
        end
    end

endmodule

// File: rtl/hs32_fetch.sv
// Instruction fetch: sequential PC, credit-limited memory requests, prefetch buffer to decode.
module hs32_fetch
    import hs32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = HS32_RESET_VEC,
    parameter int          DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [HS32_WORD-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [HS32_WORD-1:0] mem_din,
    input  logic                 mem_ack,
    input  logic                 flush,
    input  logic [HS32_WORD-1:0] newpc,
    output logic [HS32_WORD-1:0] instd,
    output logic [HS32_WORD-1:0] instpc,
    output logic                 ackd,
    input  logic                 reqd
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t         state_reg;
    logic [HS32_WORD-1:0] pc_reg;
    logic [HS32_WORD-1:0] mem_addr_reg;
    logic                 mem_rd_reg;

    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 full;
    logic                 empty;
    logic [2*HS32_WORD-1:0] head_bits;
    fetch_entry_t         head_entry;
    fetch_entry_t         push_entry;
    logic                 push;
    logic                 pop;

    assign pop        = !empty && reqd && !flush;
    assign push       = (state_reg == FS_WAIT) && mem_ack && !flush && (!full || pop);
    assign count_next = count + CW'(push) - CW'(pop);
    assign push_entry = '{pc: pc_reg, word: mem_din};
    assign head_entry = fetch_entry_t'(head_bits);

    hs32_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (2*HS32_WORD)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (push_entry),
        .head  (head_bits),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= FS_IDLE;
            pc_reg       <= RESET_VEC;
            mem_rd_reg   <= 1'b0;
            mem_addr_reg <= RESET_VEC;
        end else if (flush) begin
            pc_reg <= word_align(newpc);
            // The bus request cannot be withdrawn; an unanswered one is drained in DROP.
            case (state_reg)
                FS_WAIT, FS_DROP: begin
                    if (mem_ack) begin
                        state_reg  <= FS_IDLE;
                        mem_rd_reg <= 1'b0;
                    end else begin
                        state_reg  <= FS_DROP;
                    end
                end
                default: begin
                    state_reg  <= FS_IDLE;
                    mem_rd_reg <= 1'b0;
                end
            endcase
        end else begin
            case (state_reg)
                FS_IDLE: begin
                    if (count < CW'(DEPTH)) begin
                        state_reg    <= FS_WAIT;
                        mem_rd_reg   <= 1'b1;
                        mem_addr_reg <= pc_reg;
                    end
                end
                FS_WAIT: begin
                    if (mem_ack) begin
                        pc_reg <= pc_reg + 32'd4;
                        if (count_next < CW'(DEPTH)) begin
                            mem_addr_reg <= pc_reg + 32'd4;
                        end else begin
                            state_reg  <= FS_IDLE;
                            mem_rd_reg <= 1'b0;
                        end
                    end
                end
                FS_DROP: begin
                    if (mem_ack) begin
                        state_reg  <= FS_IDLE;
                        mem_rd_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= FS_IDLE;
                    mem_rd_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd   = mem_rd_reg;
    assign mem_addr = mem_addr_reg;
    assign ackd     = !empty;
    assign instd    = head_entry.word;
    assign instpc   = head_entry.pc;

endmodule
